// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Sized for up to 32 digits and 128 value bits.
package seg_pkg;

   localparam int NIB_W      = 4;
   localparam int MAX_DIGITS = 32;
   localparam int MAX_VAL_W  = 128;

   function automatic logic [MAX_DIGITS-1:0] sel_all_off();
      return '1;
   endfunction

   // Evaluated at 32 bits so the page*step product cannot wrap before the clamp.
   function automatic int unsigned clamp_off(int unsigned pg, int unsigned step, int unsigned lim);
      int unsigned prod;
      prod = pg * step;
      return (prod > lim) ? lim : prod;
   endfunction

   function automatic logic [NIB_W-1:0] nib_at(logic [MAX_VAL_W-1:0] v, int unsigned pos);
      return NIB_W'(v >> (NIB_W * pos));
   endfunction

endpackage

// File: rtl/seg_scan_pager_if.sv
// Display-side bundle: scan control and value in, digit select and nibble out.
// The master modport drives the value and page; the slave modport is the pager.
interface seg_scan_pager_if #(
   parameter int NIBBLES = 6,
   parameter int DIGITS  = 4,
   parameter int PAGE_W  = 2
);
   import seg_pkg::*;

   logic                     scan_en;
   logic [PAGE_W-1:0]        page;
   logic [NIB_W*NIBBLES-1:0] value;
   logic [DIGITS-1:0]        sel;
   logic [NIB_W-1:0]         hex_out;
   logic                     blank;
   logic                     frame_start;

   modport master (
      output scan_en, page, value,
      input  sel, hex_out, blank, frame_start
   );

   modport slave (
      input  scan_en, page, value,
      output sel, hex_out, blank, frame_start
   );

endinterface

// File: rtl/seg_prescaler.sv
// Purpose: divide-by-DIV tick generator with enable and synchronous clear (also used for blink timing).
// Latency: tick is high during the DIV-th enabled cycle after a clear.
// Backpressure: none; counter holds while en is low, clr wins over en.
module seg_prescaler #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_pager.sv
// Purpose: paged, self-scanning hex digit driver; leading-zero blanking when SEG_LZ_BLANK_EN is defined.
// Latency: outputs registered, one digit step per SCAN_DIV cycles; value sampled only at frame start.
// Backpressure: none; scan_en low parks the scan with all digits off.
module seg_scan_pager #(
   parameter int NIBBLES   = 6,
   parameter int DIGITS    = 4,
   parameter int PAGE_W    = 2,
   parameter int PAGE_STEP = 2,
   parameter int SCAN_DIV  = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_pager_if.slave   bus
);
   import seg_pkg::*;

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int OW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int VW = NIB_W * NIBBLES;

   localparam logic [MAX_DIGITS-1:0] SEL_OFF  = sel_all_off();
   localparam logic [IW-1:0]         IDX_LAST = IW'(DIGITS - 1);

   logic                tick;
   logic [IW-1:0]       idx;
   logic [VW-1:0]       snap;
   logic [OW-1:0]       off;
   logic [DIGITS-1:0]   sel_q;
   logic [NIB_W-1:0]    hex_q;
   logic                blank_q;
   logic                fs_q;

   logic [IW-1:0]       idx_next;
   logic                wrap;
   logic [VW-1:0]       src_val;
   logic [OW-1:0]       off_new;
   logic [OW-1:0]       src_off;
   int unsigned         pos;
   logic [NIB_W-1:0]    nib;
   logic [DIGITS-1:0]   sel_nxt;
   logic [NIB_W-1:0]    hex_nxt;
   logic                blank_nxt;
`ifdef SEG_LZ_BLANK_EN
   logic [VW-1:0]       upper;
`endif

   seg_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.scan_en),
      .clr   (!bus.scan_en),
      .tick  (tick)
   );

   // On the frame-start edge the incoming value/offset feed the outputs directly,
   // so the first digit agrees with the snapshot captured on that same edge.
   always_comb begin
      idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      wrap      = (idx_next == '0);
      off_new   = OW'(clamp_off(32'(bus.page), PAGE_STEP, NIBBLES - DIGITS));
      src_val   = wrap ? bus.value : snap;
      src_off   = wrap ? off_new : off;
      pos       = 32'(src_off) + 32'(idx_next);
      nib       = nib_at(MAX_VAL_W'(src_val), pos);
      sel_nxt   = SEL_OFF[DIGITS-1:0];
      sel_nxt[idx_next] = 1'b0;
      hex_nxt   = nib;
      blank_nxt = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      upper = src_val >> (NIB_W * pos);
      if ((idx_next != '0) && (upper == '0)) begin
         blank_nxt = 1'b1;
         hex_nxt   = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= IDX_LAST;
         snap    <= '0;
         off     <= '0;
         sel_q   <= SEL_OFF[DIGITS-1:0];
         hex_q   <= '0;
         blank_q <= 1'b0;
         fs_q    <= 1'b0;
      end else if (!bus.scan_en) begin
         idx   <= IDX_LAST;
         sel_q <= SEL_OFF[DIGITS-1:0];
         fs_q  <= 1'b0;
      end else if (tick) begin
         idx     <= idx_next;
         sel_q   <= sel_nxt;
         hex_q   <= hex_nxt;
         blank_q <= blank_nxt;
         fs_q    <= wrap;
         if (wrap) begin
            snap <= bus.value;
            off  <= off_new;
         end
      end else begin
         fs_q <= 1'b0;
      end
   end

   assign bus.sel         = sel_q;
   assign bus.hex_out     = hex_q;
   assign bus.blank       = blank_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_pager.sv
// Bench for seg_scan_pager with SCAN_DIV=4; digit-level reference model, directed then random steps.
// Honours SEG_LZ_BLANK_EN when defined for the build.
module tb_seg_scan_pager;

   localparam int NIBBLES = 6;
   localparam int DIGITS  = 4;
   localparam int PSTEP   = 2;
   localparam int DIV     = 4;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   // Reference model state, kept in plain digit/frame terms
   int        m_idx;
   int        m_off;
   logic [23:0] m_snap;
   logic [3:0] exp_sel;
   logic [3:0] exp_hex;
   logic       exp_blank;
   logic       exp_fs;

   seg_scan_pager_if #(.NIBBLES(NIBBLES), .DIGITS(DIGITS), .PAGE_W(2)) bus ();

   seg_scan_pager #(
      .NIBBLES   (NIBBLES),
      .DIGITS    (DIGITS),
      .PAGE_W    (2),
      .PAGE_STEP (PSTEP),
      .SCAN_DIV  (DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_idx = DIGITS - 1; m_off = 0; m_snap = '0;
      exp_sel = 4'hF; exp_hex = 4'h0; exp_blank = 1'b0; exp_fs = 1'b0;
   endtask

   task automatic model_disable();
      m_idx = DIGITS - 1; exp_sel = 4'hF; exp_fs = 1'b0;
   endtask

   task automatic model_tick();
      int          pos;
      logic [23:0] upper;
      m_idx  = (m_idx + 1) % DIGITS;
      exp_fs = (m_idx == 0);
      if (m_idx == 0) begin
         m_snap = bus.value;
         m_off  = int'(bus.page) * PSTEP;
         if (m_off > NIBBLES - DIGITS) m_off = NIBBLES - DIGITS;
      end
      pos   = m_off + m_idx;
      upper = m_snap >> (4 * pos);
      exp_hex   = upper[3:0];
      exp_blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      if (m_idx != 0 && upper == 24'h0) begin
         exp_blank = 1'b1;
         exp_hex   = 4'h0;
      end
`endif
      for (int d = 0; d < DIGITS; d++) exp_sel[d] = (d != m_idx);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".sel"},   32'(bus.sel),         32'(exp_sel));
      chk({tag, ".hex"},   32'(bus.hex_out),     32'(exp_hex));
      chk({tag, ".blank"}, 32'(bus.blank),       32'(exp_blank));
      chk({tag, ".fs"},    32'(bus.frame_start), 32'(exp_fs));
   endtask

   // Outputs must hold for DIV-1 cycles, then step on the DIV-th edge.
   task automatic run_digit(input string tag);
      for (int k = 0; k < DIV - 1; k++) begin
         cyc();
         chk({tag, ".hold_sel"}, 32'(bus.sel),         32'(exp_sel));
         chk({tag, ".hold_hex"}, 32'(bus.hex_out),     32'(exp_hex));
         chk({tag, ".hold_fs"},  32'(bus.frame_start), 32'h0);
      end
      cyc();
      model_tick();
      check_all(tag);
   endtask

   initial begin
      n_total = 0; n_pass = 0;
      rst_n = 1'b0;
      bus.scan_en = 1'b0; bus.page = 2'd0; bus.value = 24'h0;
      model_reset();
      cyc(); cyc();
      check_all("reset");

      bus.value = 24'h123456; bus.scan_en = 1'b1; rst_n = 1'b1;
      run_digit("first");
      chk("first_sel_const", 32'(bus.sel), 32'hE);
      chk("first_hex_const", 32'(bus.hex_out), 32'h6);
      chk("first_fs_const",  32'(bus.frame_start), 32'h1);
      for (int i = 1; i < 4; i++) run_digit("p0");
      chk("p0_last_hex_const", 32'(bus.hex_out), 32'h3);

      bus.page = 2'd1;
      for (int i = 0; i < 4; i++) run_digit("p1");
      chk("p1_last_hex_const", 32'(bus.hex_out), 32'h1);
      bus.page = 2'd3;
      for (int i = 0; i < 4; i++) run_digit("p3_clamp");
      bus.page = 2'd0;
      for (int i = 0; i < 3; i++) run_digit("p0b");

      // mid-frame value change at idx=2 stays invisible until the next frame
      bus.value = 24'hABCDEF;
      run_digit("tear");
      chk("tear_hex_const", 32'(bus.hex_out), 32'h3);
      for (int i = 0; i < 4; i++) run_digit("newval");
      chk("newval_hex_const", 32'(bus.hex_out), 32'hC);

      run_digit("pre_dis0");
      run_digit("pre_dis1");
      bus.scan_en = 1'b0;
      cyc();
      model_disable();
      check_all("disable");
      cyc();
      check_all("disable_hold");
      bus.scan_en = 1'b1;
      run_digit("reenable");
      chk("reenable_fs_const", 32'(bus.frame_start), 32'h1);
      for (int i = 1; i < 4; i++) run_digit("reenable_rest");

      bus.value = 24'h000012;
      for (int i = 0; i < 4; i++) run_digit("lz12");
      bus.value = 24'h000000;
      for (int i = 0; i < 4; i++) run_digit("lz0");
      bus.value = 24'h0F0000;
      for (int i = 0; i < 4; i++) run_digit("lzhi");

      run_digit("pre_rst0");
      run_digit("pre_rst1");
      cyc();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      cyc();
      bus.value = 24'h123456; bus.page = 2'd0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) run_digit("restart");

      for (int it = 0; it < 60; it++) begin
         if (m_idx == DIGITS - 1) begin
            bus.value = 24'($urandom >> $urandom_range(0, 31));
            bus.page  = 2'($urandom);
         end else if ($urandom_range(0, 3) == 0) begin
            bus.value = 24'($urandom);
            bus.page  = 2'($urandom);
         end
         if ($urandom_range(0, 11) == 0) begin
            bus.scan_en = 1'b0;
            cyc();
            model_disable();
            check_all("rnd_disable");
            bus.scan_en = 1'b1;
         end
         run_digit("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seg_scan_pager.md
# seg_scan_pager

Self-scanning, paged hex display driver for the multiplexed 7-segment digits on the board. Snapshots a wide nibble-packed value once per frame, selects a window of DIGITS nibbles starting at a page-dependent offset, and walks an active-low digit select across the window at a prescaled rate. Sits between the clock/counter datapath and the hex-to-segment decoder, replacing the external digit-select drive and the fixed two-page nibble mux of the previous generation.

## Interface
- NIBBLES, 6: number of 4-bit nibbles in `value`.
- DIGITS, 4: number of physical digits; window width in nibbles; 1 ≤ DIGITS ≤ NIBBLES.
- PAGE_W, 2: width of `page`.
- PAGE_STEP, 2: nibble offset added per page step.
- SCAN_DIV, 50000: clock cycles per digit dwell; ≥ 2.

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scan_en  in  1  scanning enable.
- page  in  PAGE_W  requested page; sampled at frame start only.
- value  in  4*NIBBLES  nibble-packed display value, nibble 0 = bits [3:0].
- sel  out  DIGITS  active-low one-cold digit select; bit 0 = rightmost digit.
- hex_out  out  4  nibble for the selected digit.
- blank  out  1  selected digit must show no segments.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.

## Operation
- Reset values: sel all ones, hex_out 4'h0, blank 0, frame_start 0, prescaler 0, idx DIGITS-1, snapshot 0, offset 0.
- Prescaler counts 0..SCAN_DIV-1 while scan_en=1; tick when it equals SCAN_DIV-1, then it returns to 0.
- On tick: idx advances (idx+1) mod DIGITS. On wrap to 0 (frame start): snapshot ← value, off ← min(page*PAGE_STEP, NIBBLES-DIGITS), frame_start=1.
- Outputs registered on the tick edge: sel = ~(1 << idx_next); hex_out = nibble[off+idx_next] of snapshot. On a frame-start edge, use the incoming value and new offset, so hex_out is consistent with the snapshot being written.
- Between ticks, sel, hex_out, and blank hold. `value` and `page` changes mid-frame are invisible until the next frame start, so there is no tearing.
- Offset arithmetic uses at least PAGE_W+clog2(NIBBLES)+1 bits, so the multiply cannot wrap before the clamp. Pages beyond the clamp show the top window.
- scan_en=0: on the next edge, sel goes all ones, prescaler clears, idx ← DIGITS-1, frame_start=0, and hex_out/blank/snapshot hold. Re-enable starts a fresh frame SCAN_DIV cycles later.
- Reset asserted mid-frame forces all reset values immediately; no partial frame resumes.

## Timing
- First digit is active SCAN_DIV cycles after rst_n deasserts with scan_en=1. Frame period is DIGITS*SCAN_DIV cycles.
- Value-to-display latency is at most one frame plus one cycle, with sampling only at frame start.
- Outputs are registered with no combinational path from inputs to outputs.
- sel, hex_out, blank, and frame_start change on the same edge.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero blanking is enabled.
  - A digit with idx ≠ 0 has blank=1 and hex_out=4'h0 when its nibble and every higher nibble of the full snapshot (up to NIBBLES-1) are zero.
  - Digit 0 is never blanked.
  - The blank decision is registered with hex_out.
- Not defined: blank is constant 0 and hex_out always shows the nibble.

## Structure
- A shared package `seg_pkg` holds:
  - the nibble width constant (4);
  - the all-off select helper;
  - a clamped-offset function;
  - a nibble-extract function used by the decoder side.
- Sub-module `seg_prescaler`: parametrised SCAN_DIV counter with enable and synchronous clear, producing `tick`. It is reused for the colon/blink timer.

## Test plan
All scenarios use SCAN_DIV=4, defaults otherwise.
- Reset release, scan_en=1, value=24'h123456, page=0 -> after 4 cycles: sel=4'b1110, hex_out=6, frame_start=1. Then every 4 cycles: (4'b1101,5), (4'b1011,4), (4'b0111,3), then wrap.
- page=1 -> window nibbles 2..5: hex_out sequence 4,3,2,1. page=3 -> clamped offset 2, same sequence.
- value changes to 24'hABCDEF while idx=2 -> remaining digits of the frame still show the old snapshot. The next frame shows F,E,D,C.
- scan_en dropped while idx=1 -> next edge: sel=4'hF. Re-raise -> digit 0 after 4 cycles with frame_start=1.
- With SEG_LZ_BLANK_EN, value=24'h000012, page=0 -> blank is 0 on digits 0 and 1 and 1 on digits 2 and 3. value=0 -> only digit 0 is unblanked, showing 0.
- rst_n pulsed low mid-frame -> sel=4'hF, hex_out=0, frame_start=0 asynchronously. Restart follows the first scenario.
